// File: rtl/letter_motion_if.sv
// letter_motion_if: sync-generator coordinates and switches in; letter square
// position, colour, visibility and frame pulse out.
// master = side that drives the pixel coordinates and switches (sync gen / bench),
// slave  = letter_motion_ctrl.
interface letter_motion_if;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       run;
    logic [2:0] sw_rgb;
    logic [9:0] letter_x;
    logic [9:0] letter_y;
    logic [2:0] letter_rgb;
    logic       letter_visible;
    logic       frame_tick;

    modport master (
        output pix_x, pix_y, run, sw_rgb,
        input  letter_x, letter_y, letter_rgb, letter_visible, frame_tick
    );

    modport slave (
        input  pix_x, pix_y, run, sw_rgb,
        output letter_x, letter_y, letter_rgb, letter_visible, frame_tick
    );
endinterface

// File: rtl/letter_motion_ctrl.sv
// letter_motion_ctrl: frame-rate sequencer for the VGA letter generator.
// Detects end of the visible frame, bounces the letter square around the
// screen, latches the colour switches once per frame.
// Optional blinking glyph: define LETTER_MOTION_BLINK_EN.
//
// state | meaning
// ------+------------------------
// DR    | moving down and right
// DL    | moving down and left
// UR    | moving up and right
// UL    | moving up and left
// Encoding: bit1 = up, bit0 = left.
module letter_motion_ctrl #(
    parameter int SIZE         = 8,
    parameter int MAX_X        = 640,
    parameter int MAX_Y        = 480,
    parameter int STEP         = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic           clk,
    input  logic           reset,
    letter_motion_if.slave bus
);

    localparam logic [1:0] DR = 2'b00;
    localparam logic [1:0] DL = 2'b01;
    localparam logic [1:0] UR = 2'b10;
    localparam logic [1:0] UL = 2'b11;

    localparam logic [9:0]  END_ROW = 10'(MAX_Y + 1);
    localparam logic [10:0] X_LIM   = 11'(MAX_X - SIZE);
    localparam logic [10:0] Y_LIM   = 11'(MAX_Y - SIZE);
    localparam logic [10:0] STEP_W  = 11'(STEP);

    localparam logic [9:0] X_RST   = 10'd320;
    localparam logic [9:0] Y_RST   = 10'd240;
    localparam logic [2:0] RGB_RST = 3'b100;

    // Reject parameter sets where a single step could jump past a bound.
    if (STEP < 1 || STEP >= SIZE || BLINK_FRAMES < 1) begin : g_bad_params
        $error("letter_motion_ctrl: illegal parameter combination");
    end

    logic        end_cond;
    logic        c_q, c_qq;
    logic        frame_tick;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [1:0]  state_q, state_d;
    logic [2:0]  rgb_q, rgb_d;
    logic [10:0] x_inc, x_dec, y_inc, y_dec;
    logic        left_d, up_d;

    assign end_cond   = (bus.pix_y == END_ROW) && (bus.pix_x == 10'd0);
    assign frame_tick = c_q & ~c_qq;

    // Edge-detect the end-of-frame coordinate; a held coordinate yields one pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q  <= 1'b0;
            c_qq <= 1'b0;
        end else begin
            c_q  <= end_cond;
            c_qq <= c_q;
        end
    end

    // Next position/direction: step each axis, clamp at the edge and flip.
    always_comb begin
        x_inc   = {1'b0, x_q} + STEP_W;
        x_dec   = {1'b0, x_q} - STEP_W;
        y_inc   = {1'b0, y_q} + STEP_W;
        y_dec   = {1'b0, y_q} - STEP_W;
        x_d     = x_q;
        y_d     = y_q;
        left_d  = state_q[0];
        up_d    = state_q[1];
        rgb_d   = rgb_q;
        state_d = state_q;
        if (frame_tick) begin
            rgb_d = bus.sw_rgb;
            if (bus.run) begin
                if (!state_q[0]) begin
                    if (x_inc >= X_LIM) begin
                        x_d    = X_LIM[9:0];
                        left_d = 1'b1;
                    end else begin
                        x_d = x_inc[9:0];
                    end
                end else begin
                    if ({1'b0, x_q} <= STEP_W) begin
                        x_d    = 10'd0;
                        left_d = 1'b0;
                    end else begin
                        x_d = x_dec[9:0];
                    end
                end
                if (!state_q[1]) begin
                    if (y_inc >= Y_LIM) begin
                        y_d  = Y_LIM[9:0];
                        up_d = 1'b1;
                    end else begin
                        y_d = y_inc[9:0];
                    end
                end else begin
                    if ({1'b0, y_q} <= STEP_W) begin
                        y_d  = 10'd0;
                        up_d = 1'b0;
                    end else begin
                        y_d = y_dec[9:0];
                    end
                end
                case ({up_d, left_d})
                    2'b00:   state_d = DR;
                    2'b01:   state_d = DL;
                    2'b10:   state_d = UR;
                    default: state_d = UL;
                endcase
            end
        end
    end

    // Position, direction and colour registers; reset beats a coincident tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= X_RST;
            y_q     <= Y_RST;
            state_q <= DR;
            rgb_q   <= RGB_RST;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            state_q <= state_d;
            rgb_q   <= rgb_d;
        end
    end

`ifdef LETTER_MOTION_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_q, blink_d;
    logic          vis_q, vis_d;

    // Frame counter for the blink phase; runs whether or not the square moves.
    always_comb begin
        blink_d = blink_q;
        vis_d   = vis_q;
        if (frame_tick) begin
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                vis_d   = ~vis_q;
            end else begin
                blink_d = blink_q + 1'b1;
            end
        end
    end

    // Blink counter and visibility registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= '0;
            vis_q   <= 1'b1;
        end else begin
            blink_q <= blink_d;
            vis_q   <= vis_d;
        end
    end

    assign bus.letter_visible = vis_q;
`else
    assign bus.letter_visible = 1'b1;
`endif

    assign bus.letter_x   = x_q;
    assign bus.letter_y   = y_q;
    assign bus.letter_rgb = rgb_q;
    assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_letter_motion_ctrl.sv
// tb_letter_motion_ctrl: directed table vectors plus hand-written frame
// sequences for bounce, freeze, colour, blink and reset corner cases.
module tb_letter_motion_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   tick_cnt = 0;

    letter_motion_if bus ();

    letter_motion_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.frame_tick) tick_cnt++;

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic       run;
        logic [2:0] sw;
        logic       tick;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [2:0] rgb;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.pix_x = 10'd0;
        bus.pix_y = 10'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One frame: end coordinate held for two clocks, then released.
    // Entered and left right after a falling edge.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pix_x = 10'd0;
            bus.pix_y = 10'd481;
            @(negedge clk);
            @(negedge clk);
            bus.pix_y = 10'd0;
            @(negedge clk);
        end
    endtask

    task automatic chk_pos(input string name, input int ex, input int ey);
        chk({name, "_x"}, int'(bus.letter_x), ex);
        chk({name, "_y"}, int'(bus.letter_y), ey);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        vecs[0]  = '{10'd0, 10'd0,   1'b1, 3'b100, 1'b0, 10'd320, 10'd240, 3'b100};
        vecs[1]  = '{10'd0, 10'd481, 1'b1, 3'b100, 1'b1, 10'd320, 10'd240, 3'b100};
        vecs[2]  = '{10'd0, 10'd481, 1'b1, 3'b100, 1'b0, 10'd321, 10'd241, 3'b100};
        vecs[3]  = '{10'd0, 10'd481, 1'b1, 3'b100, 1'b0, 10'd321, 10'd241, 3'b100};
        vecs[4]  = '{10'd0, 10'd481, 1'b1, 3'b100, 1'b0, 10'd321, 10'd241, 3'b100};
        vecs[5]  = '{10'd5, 10'd0,   1'b1, 3'b100, 1'b0, 10'd321, 10'd241, 3'b100};
        vecs[6]  = '{10'd0, 10'd481, 1'b0, 3'b010, 1'b1, 10'd321, 10'd241, 3'b100};
        vecs[7]  = '{10'd0, 10'd481, 1'b0, 3'b010, 1'b0, 10'd321, 10'd241, 3'b010};
        vecs[8]  = '{10'd0, 10'd0,   1'b0, 3'b001, 1'b0, 10'd321, 10'd241, 3'b010};
        vecs[9]  = '{10'd0, 10'd481, 1'b1, 3'b001, 1'b1, 10'd321, 10'd241, 3'b010};
        vecs[10] = '{10'd0, 10'd0,   1'b1, 3'b110, 1'b0, 10'd322, 10'd242, 3'b110};
        vecs[11] = '{10'd0, 10'd480, 1'b1, 3'b110, 1'b0, 10'd322, 10'd242, 3'b110};

        bus.pix_x  = 10'd0;
        bus.pix_y  = 10'd0;
        bus.run    = 1'b1;
        bus.sw_rgb = 3'b100;

        // Reset values
        do_reset();
        chk_pos("rst", 320, 240);
        chk("rst_rgb", int'(bus.letter_rgb), 4);
        chk("rst_vis", int'(bus.letter_visible), 1);
        chk("rst_tick", int'(bus.frame_tick), 0);

        // Cycle-accurate table: single tick, held coordinate, freeze, colour
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.pix_x  = vecs[i].px;
            bus.pix_y  = vecs[i].py;
            bus.run    = vecs[i].run;
            bus.sw_rgb = vecs[i].sw;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_tick", i), int'(bus.frame_tick), int'(vecs[i].tick));
            chk($sformatf("vec%0d_x", i), int'(bus.letter_x), int'(vecs[i].ex));
            chk($sformatf("vec%0d_y", i), int'(bus.letter_y), int'(vecs[i].ey));
            chk($sformatf("vec%0d_rgb", i), int'(bus.letter_rgb), int'(vecs[i].rgb));
        end

        // Bounce: bottom edge at tick 232, right edge at tick 312, then both back off
        bus.run = 1'b1;
        bus.sw_rgb = 3'b100;
        do_reset();
        t0 = tick_cnt;
        frames(232);
        chk("bounce232_ticks", tick_cnt - t0, 232);
        chk_pos("bounce232", 552, 472);
        chk("bounce232_state", int'(dut.state_q), 2);
        frames(80);
        chk_pos("bounce312", 632, 392);
        chk("bounce312_state", int'(dut.state_q), 3);
        frames(1);
        chk_pos("bounce313", 631, 391);

        // Freeze, and colour switch changed mid-frame
        bus.run = 1'b0;
        t0 = tick_cnt;
        frames(10);
        chk("freeze_ticks", tick_cnt - t0, 10);
        chk_pos("freeze", 631, 391);
        bus.sw_rgb = 3'b010;
        repeat (3) @(negedge clk);
        chk("colour_hold", int'(bus.letter_rgb), 4);
        frames(1);
        chk("colour_new", int'(bus.letter_rgb), 2);
        chk_pos("colour_freeze", 631, 391);

        // Blink phase
        bus.run = 1'b1;
        do_reset();
        frames(29);
        chk("blink29", int'(bus.letter_visible), 1);
        frames(1);
`ifdef LETTER_MOTION_BLINK_EN
        chk("blink30", int'(bus.letter_visible), 0);
        frames(29);
        chk("blink59", int'(bus.letter_visible), 0);
        frames(1);
        chk("blink60", int'(bus.letter_visible), 1);
`else
        chk("blink30", int'(bus.letter_visible), 1);
        frames(30);
        chk("blink60", int'(bus.letter_visible), 1);
`endif

        // Reset arriving on the update edge of tick 100
        bus.sw_rgb = 3'b001;
        do_reset();
        frames(99);
        chk_pos("pre_tick100", 419, 339);
        bus.pix_y = 10'd481;
        @(negedge clk);
        chk("tick100_pulse", int'(bus.frame_tick), 1);
        reset = 1'b1;
        bus.pix_y = 10'd0;
        @(negedge clk);
        reset = 1'b0;
        chk_pos("rst_tick100", 320, 240);
        chk("rst_tick100_rgb", int'(bus.letter_rgb), 4);
        chk("rst_tick100_tick", int'(bus.frame_tick), 0);
        frames(1);
        chk_pos("after_rst_tick", 321, 241);

        // End coordinate still present when reset releases: exactly one tick
        @(negedge clk);
        reset = 1'b1;
        bus.pix_y = 10'd481;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        t0 = tick_cnt;
        @(negedge clk);
        chk("held_rst_pulse", int'(bus.frame_tick), 1);
        @(negedge clk);
        chk("held_rst_low", int'(bus.frame_tick), 0);
        chk_pos("held_rst", 321, 241);
        repeat (3) @(negedge clk);
        chk("held_rst_ticks", tick_cnt - t0, 1);
        bus.pix_y = 10'd0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
